// File: rtl/boiler_stack_ctrl.sv
// ---------------------------------------------------------------------------
// boiler_stack_ctrl
//
// Colour-layer controller for one boiler in the sort game. Holds up to four
// 3-bit colour codes as a bottom-to-top stack, accepts layers through a push
// handshake and, once selected and confirmed, pours out the top run of
// same-coloured layers through a pop (pout) handshake.
//
// Optional feature macro: BOILER_SOLVED_DETECT_EN
//   defined   -> solved is registered (full and all four slots equal) and
//                blocks selection of a completed boiler
//   undefined -> solved is tied low, selection is never gated
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   sel_btn, conf_btn     one-cycle debounced select / confirm pulses
//   push_valid/colour     incoming layer, push_ready back-pressure
//   push_err              one-cycle pulse when an illegal code was consumed
//   pout_valid/colour     outgoing layer, pout_ready from destination
//   colour1..colour4      slot codes, colour1 is the bottom
//   level, full, empty    occupancy
//   selected, confirmed   state==SEL / state==POUR, for the renderer
//   pour_count            layers sent in the current or most recent pour
//   solved                boiler complete
// ---------------------------------------------------------------------------
module boiler_stack_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       sel_btn,
  input  logic       conf_btn,
  input  logic       push_valid,
  input  logic [2:0] push_colour,
  output logic       push_ready,
  output logic       push_err,
  output logic       pout_valid,
  output logic [2:0] pout_colour,
  input  logic       pout_ready,
  output logic [2:0] colour1,
  output logic [2:0] colour2,
  output logic [2:0] colour3,
  output logic [2:0] colour4,
  output logic [2:0] level,
  output logic       full,
  output logic       empty,
  output logic       selected,
  output logic       confirmed,
  output logic [2:0] pour_count,
  output logic       solved
);

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef enum logic [1:0] {IDLE, SEL, POUR} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   slot_q [DEPTH];
  logic [CW-1:0]   slot_d [DEPTH];
  logic [2:0]      level_q, level_d;
  logic [2:0]      pour_count_q, pour_count_d;
  logic            push_err_q, push_err_d;
  logic            solved_lock;

  logic            full_w, empty_w;
  logic [2:0]      lvl_m1;
  logic [1:0]      lvl_m2;
  logic [CW-1:0]   top_w, below_w;
  logic            push_ready_w, push_fire, push_legal, pop_fire, start_pour;

  // Occupancy, top-of-stack and the layer directly beneath it. The
  // layer beneath decides whether a pour continues after a beat.
  always_comb begin
    full_w       = (level_q == 3'd4);
    empty_w      = (level_q == 3'd0);
    lvl_m1       = level_q - 3'd1;
    lvl_m2       = level_q[1:0] - 2'd2;
    top_w        = empty_w ? '0 : slot_q[lvl_m1[1:0]];
    below_w      = (level_q >= 3'd2) ? slot_q[lvl_m2] : '0;
    push_ready_w = !full_w && (state_q != POUR);
    push_fire    = push_valid && push_ready_w;
    push_legal   = (push_colour != 3'b000) && (push_colour != 3'b111);
    pop_fire     = (state_q == POUR) && pout_ready;
    start_pour   = (state_q == SEL) && !sel_btn && conf_btn;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. sel_btn wins over conf_btn in SEL, and an abort in
  // POUR still lets a same-cycle handshake complete in the datapath.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (sel_btn && !empty_w && !solved_lock) state_d = SEL;
      SEL: begin
        if (sel_btn)       state_d = IDLE;
        else if (conf_btn) state_d = POUR;
      end
      POUR: begin
        if (sel_btn) state_d = IDLE;
        else if (pop_fire) begin
          if ((level_q >= 3'd2) && (below_w == top_w)) state_d = POUR;
          else                                         state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. Push and pop are mutually exclusive because
  // push_ready is low throughout POUR.
  always_comb begin
    slot_d       = slot_q;
    level_d      = level_q;
    pour_count_d = pour_count_q;
    push_err_d   = push_fire && !push_legal;
    if (push_fire && push_legal) begin
      slot_d[level_q[1:0]] = push_colour;
      level_d              = level_q + 3'd1;
    end else if (pop_fire) begin
      slot_d[lvl_m1[1:0]] = '0;
      level_d             = lvl_m1;
    end
    if (start_pour)    pour_count_d = 3'd0;
    else if (pop_fire) pour_count_d = pour_count_q + 3'd1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      level_q      <= 3'd0;
      pour_count_q <= 3'd0;
      push_err_q   <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      level_q      <= level_d;
      pour_count_q <= pour_count_d;
      push_err_q   <= push_err_d;
    end
  end

`ifdef BOILER_SOLVED_DETECT_EN
  logic solved_q;

  // Completion is judged from the registered slots, so it trails the
  // change that causes it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) solved_q <= 1'b0;
    else       solved_q <= full_w && (slot_q[0] == slot_q[1]) &&
                           (slot_q[1] == slot_q[2]) && (slot_q[2] == slot_q[3]);
  end

  always_comb begin
    solved_lock = solved_q;
    solved      = solved_q;
  end
`else
  always_comb begin
    solved_lock = 1'b0;
    solved      = 1'b0;
  end
`endif

  // Output decode, purely from registers
  always_comb begin
    push_ready  = push_ready_w;
    push_err    = push_err_q;
    pout_valid  = (state_q == POUR);
    pout_colour = top_w;
    colour1     = slot_q[0];
    colour2     = slot_q[1];
    colour3     = slot_q[2];
    colour4     = slot_q[3];
    level       = level_q;
    full        = full_w;
    empty       = empty_w;
    selected    = (state_q == SEL);
    confirmed   = (state_q == POUR);
    pour_count  = pour_count_q;
  end

endmodule

// File: tb/tb_boiler_stack_ctrl.sv
// Self-checking bench for boiler_stack_ctrl: directed scenarios plus a
// randomized run compared against a queue-based model of the boiler.
module tb_boiler_stack_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sel_btn = 1'b0, conf_btn = 1'b0;
  logic       push_valid = 1'b0;
  logic [2:0] push_colour = 3'd0;
  logic       push_ready, push_err, pout_valid;
  logic [2:0] pout_colour;
  logic       pout_ready = 1'b0;
  logic [2:0] colour1, colour2, colour3, colour4, level, pour_count;
  logic       full, empty, selected, confirmed, solved;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: stack as a queue (index 0 = bottom), state 0/1/2 =
  // idle/selected/pouring.
  int mStk[$];
  int mSt = 0;
  int mPc = 0;
  bit mErr = 0;
  bit mSolved = 0;

  boiler_stack_ctrl dut (
    .clk(clk), .reset(reset), .sel_btn(sel_btn), .conf_btn(conf_btn),
    .push_valid(push_valid), .push_colour(push_colour), .push_ready(push_ready),
    .push_err(push_err), .pout_valid(pout_valid), .pout_colour(pout_colour),
    .pout_ready(pout_ready), .colour1(colour1), .colour2(colour2),
    .colour3(colour3), .colour4(colour4), .level(level), .full(full),
    .empty(empty), .selected(selected), .confirmed(confirmed),
    .pour_count(pour_count), .solved(solved)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of inputs, advance the model by the game rules and
  // let the DUT take the same edge; outputs are observed 1 time unit later.
  task automatic step(input bit s, input bit c, input bit pv,
                      input logic [2:0] col, input bit pr);
    int  sz;
    bit  rdy, pushf, popf, lg, lock, nSolved;
    int  sent;
    int  nst;
    sel_btn = s; conf_btn = c; push_valid = pv; push_colour = col; pout_ready = pr;
    sz      = mStk.size();
    rdy     = (sz < 4) && (mSt != 2);
    pushf   = pv && rdy;
    popf    = (mSt == 2) && pr;
    lg      = (col != 3'd0) && (col != 3'd7);
    nSolved = (sz == 4) && (mStk[0] == mStk[1]) && (mStk[1] == mStk[2]) && (mStk[2] == mStk[3]);
`ifdef BOILER_SOLVED_DETECT_EN
    lock = mSolved;
`else
    lock = 1'b0;
    nSolved = 1'b0;
`endif
    nst  = mSt;
    sent = 0;
    if (pushf && lg) mStk.push_back(int'(col));
    if (popf) begin
      sent = mStk.pop_back();
      mPc++;
    end
    case (mSt)
      0: if (s && sz > 0 && !lock) nst = 1;
      1: if (s) nst = 0;
         else if (c) begin nst = 2; mPc = 0; end
      default: if (s) nst = 0;
               else if (popf) nst = (mStk.size() > 0 && mStk[$] == sent) ? 2 : 0;
    endcase
    mSt = nst;
    mErr = pushf && !lg;
    mSolved = nSolved;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sel_btn = 0; conf_btn = 0; push_valid = 0; push_colour = 0; pout_ready = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mStk.delete();
    mSt = 0; mPc = 0; mErr = 0; mSolved = 0;
  endtask

  task automatic test_reset();
    do_reset();
    nChecks++;
    if ({colour4, colour3, colour2, colour1} !== 12'd0) begin
      nFails++; $display("[TB] FAIL reset_colours: got %h expected 000", {colour4, colour3, colour2, colour1});
    end
    nChecks++;
    if (level !== 3'd0) begin nFails++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    nChecks++;
    if ({empty, full, push_ready, push_err, pout_valid, selected, confirmed, solved} !== 8'b1010_0000) begin
      nFails++; $display("[TB] FAIL reset_flags: got %b expected 10100000",
                         {empty, full, push_ready, push_err, pout_valid, selected, confirmed, solved});
    end
    nChecks++;
    if (pour_count !== 3'd0) begin nFails++; $display("[TB] FAIL reset_pour_count: got %0d expected 0", pour_count); end
  endtask

  task automatic test_fill();
    do_reset();
    step(0, 0, 1, 3'd2, 1); step(0, 0, 1, 3'd2, 1);
    step(0, 0, 1, 3'd5, 1); step(0, 0, 1, 3'd1, 1);
    nChecks++;
    if ({colour1, colour2, colour3, colour4} !== {3'd2, 3'd2, 3'd5, 3'd1}) begin
      nFails++; $display("[TB] FAIL fill_colours: got %0d%0d%0d%0d expected 2251", colour1, colour2, colour3, colour4);
    end
    nChecks++;
    if ({level, full, push_ready} !== {3'd4, 1'b1, 1'b0}) begin
      nFails++; $display("[TB] FAIL fill_status: got level=%0d full=%b ready=%b expected 4 1 0", level, full, push_ready);
    end
    step(0, 0, 1, 3'd3, 1);
    nChecks++;
    if (level !== 3'd4 || colour4 !== 3'd1) begin
      nFails++; $display("[TB] FAIL fill_fifth_push: got level=%0d colour4=%0d expected 4 1", level, colour4);
    end
  endtask

  task automatic test_push_err();
    do_reset();
    step(0, 0, 1, 3'd7, 0);
    nChecks++;
    if ({push_err, level, colour1} !== {1'b1, 3'd0, 3'd0}) begin
      nFails++; $display("[TB] FAIL push_err_pulse: got err=%b level=%0d c1=%0d expected 1 0 0", push_err, level, colour1);
    end
    step(0, 0, 0, 3'd0, 0);
    nChecks++;
    if (push_err !== 1'b0) begin nFails++; $display("[TB] FAIL push_err_clear: got %b expected 0", push_err); end
  endtask

  task automatic test_pour_run();
    do_reset();
    step(0, 0, 1, 3'd4, 0); step(0, 0, 1, 3'd3, 0);
    step(0, 0, 1, 3'd3, 0); step(0, 0, 1, 3'd3, 0);
    step(1, 0, 0, 3'd0, 0);
    nChecks++;
    if (selected !== 1'b1) begin nFails++; $display("[TB] FAIL pour_selected: got %b expected 1", selected); end
    step(0, 1, 0, 3'd0, 0);
    nChecks++;
    if ({confirmed, pout_valid, pout_colour, pour_count} !== {1'b1, 1'b1, 3'd3, 3'd0}) begin
      nFails++; $display("[TB] FAIL pour_start: got conf=%b valid=%b col=%0d pc=%0d expected 1 1 3 0",
                         confirmed, pout_valid, pout_colour, pour_count);
    end
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (pout_valid !== 1'b1 || pout_colour !== 3'd3) begin
        nFails++; $display("[TB] FAIL pour_beat%0d: got valid=%b col=%0d expected 1 3", i, pout_valid, pout_colour);
      end
      step(0, 0, 0, 3'd0, 1);
    end
    nChecks++;
    if ({confirmed, pout_valid, level, pour_count} !== {1'b0, 1'b0, 3'd1, 3'd3}) begin
      nFails++; $display("[TB] FAIL pour_end: got conf=%b valid=%b level=%0d pc=%0d expected 0 0 1 3",
                         confirmed, pout_valid, level, pour_count);
    end
    nChecks++;
    if ({colour1, colour2, colour3, colour4} !== {3'd4, 9'd0}) begin
      nFails++; $display("[TB] FAIL pour_slots: got %0d%0d%0d%0d expected 4000", colour1, colour2, colour3, colour4);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(0, 0, 1, 3'd1, 0); step(0, 0, 1, 3'd6, 0); step(0, 0, 1, 3'd6, 0);
    step(1, 0, 0, 3'd0, 0); step(0, 1, 0, 3'd0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 3'd0, 0);
      nChecks++;
      if ({pout_valid, pout_colour, level} !== {1'b1, 3'd6, 3'd3}) begin
        nFails++; $display("[TB] FAIL stall%0d: got valid=%b col=%0d level=%0d expected 1 6 3", i, pout_valid, pout_colour, level);
      end
    end
    step(0, 0, 0, 3'd0, 1); step(0, 0, 0, 3'd0, 1);
    nChecks++;
    if ({pour_count, level, confirmed} !== {3'd2, 3'd1, 1'b0}) begin
      nFails++; $display("[TB] FAIL stall_release: got pc=%0d level=%0d conf=%b expected 2 1 0", pour_count, level, confirmed);
    end
  endtask

  task automatic test_abort();
    do_reset();
    step(0, 0, 1, 3'd5, 0); step(0, 0, 1, 3'd5, 0); step(0, 0, 1, 3'd5, 0);
    step(1, 0, 0, 3'd0, 0); step(0, 1, 0, 3'd0, 0);
    step(1, 0, 0, 3'd0, 1);
    nChecks++;
    if ({level, selected, confirmed, pour_count} !== {3'd2, 1'b0, 1'b0, 3'd1}) begin
      nFails++; $display("[TB] FAIL abort: got level=%0d sel=%b conf=%b pc=%0d expected 2 0 0 1",
                         level, selected, confirmed, pour_count);
    end
  endtask

  task automatic test_solved();
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 1, 3'd2, 0);
    step(0, 0, 0, 3'd0, 0);
    step(1, 0, 0, 3'd0, 0);
`ifdef BOILER_SOLVED_DETECT_EN
    nChecks++;
    if ({solved, selected} !== 2'b10) begin
      nFails++; $display("[TB] FAIL solved_lock: got solved=%b sel=%b expected 1 0", solved, selected);
    end
`else
    nChecks++;
    if ({solved, selected} !== 2'b01) begin
      nFails++; $display("[TB] FAIL solved_off: got solved=%b sel=%b expected 0 1", solved, selected);
    end
`endif
  endtask

  task automatic test_random();
    logic [11:0] expCol;
    logic [6:0]  expFlags;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           3'($urandom_range(0, 7)), $urandom_range(0, 2) != 0);
      expCol = '0;
      for (int i = 0; i < mStk.size(); i++) expCol[i*3 +: 3] = 3'(mStk[i]);
      expFlags = {mStk.size() == 4, mStk.size() == 0, (mStk.size() < 4) && (mSt != 2),
                  mErr, mSt == 2, mSt == 1, mSolved};
      nChecks++;
      if ({colour4, colour3, colour2, colour1} !== expCol || level !== 3'(mStk.size())) begin
        nFails++; $display("[TB] FAIL rand_stack@%0d: got %h/%0d expected %h/%0d", n,
                           {colour4, colour3, colour2, colour1}, level, expCol, mStk.size());
      end
      nChecks++;
      if ({full, empty, push_ready, push_err, pout_valid, selected, solved} !== expFlags ||
          confirmed !== (mSt == 2) || pour_count !== 3'(mPc)) begin
        nFails++; $display("[TB] FAIL rand_ctrl@%0d: got %b pc=%0d expected %b pc=%0d", n,
                           {full, empty, push_ready, push_err, pout_valid, selected, solved}, pour_count, expFlags, mPc);
      end
      if (mSt == 2) begin
        nChecks++;
        if (pout_colour !== 3'(mStk[$])) begin
          nFails++; $display("[TB] FAIL rand_pout@%0d: got %0d expected %0d", n, pout_colour, mStk[$]);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] boiler_stack_ctrl bench start");
    test_reset();
    test_fill();
    test_push_err();
    test_pour_run();
    test_backpressure();
    test_abort();
    test_solved();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/boiler_stack_ctrl.md
# boiler_stack_ctrl

Colour-layer controller for one boiler in the sort game. It holds up to four 3-bit colour codes as a bottom-to-top stack and accepts poured-in layers through a push handshake. When the player selects and confirms the boiler, it pours out the top run of same-coloured layers through a pop handshake. Its slot, selected and confirmed outputs drive the boiler sprite renderer's colour1..colour4, selected and confirmed inputs directly. A game-level arbiter links the pour-out port of one controller to the push port of another.

## Interface
- DEPTH, 4: number of layer slots; fixed at 4 to match the renderer.
- CW, 3: colour code width. Code 3'b000 means empty (white). Codes 1..6 are legal colours. Code 3'b111 is illegal.

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- sel_btn  in  1  one-cycle select pulse, already debounced
- conf_btn  in  1  one-cycle confirm pulse, already debounced
- push_valid  in  1  incoming layer present
- push_colour  in  3  incoming layer code
- push_ready  out  1  controller can accept a layer
- push_err  out  1  one-cycle pulse: an illegal code was consumed
- pout_valid  out  1  outgoing layer present
- pout_colour  out  3  outgoing layer code
- pout_ready  in  1  destination accepts the outgoing layer
- colour1..colour4  out  3 each  slot codes; colour1 is the bottom, colour4 is the top
- level  out  3  occupied slot count, 0..4
- full, empty  out  1 each  level==4 / level==0
- selected  out  1  state==SEL
- confirmed  out  1  state==POUR
- pour_count  out  3  layers sent in the current or most recent pour
- solved  out  1  boiler complete (see Configuration)

## Operation
- Storage: slot[1..4] registers plus level. Occupied slots are always contiguous from slot 1. Every unoccupied slot holds 3'b000.
- Top colour is slot[level], or 3'b000 when empty.
- States: IDLE, SEL, POUR.
  - IDLE to SEL: sel_btn while !empty. sel_btn while empty is ignored.
  - SEL to IDLE: sel_btn.
  - SEL to POUR: conf_btn. On this edge pour_count clears to 0.
  - conf_btn in IDLE is ignored.
- Push (accepted when push_valid && push_ready):
  - push_ready = !full && state!=POUR.
  - Legal code: slot[level+1] takes the code and level increments.
  - Code 000 or 111: the beat is consumed, storage is unchanged, and push_err pulses for one cycle.
- POUR:
  - pout_valid = 1 and pout_colour = top colour.
  - On a pout handshake: slot[level] becomes 000, level decrements, pour_count increments.
  - After the handshake, stay in POUR only if level>0 after the decrement and the new top equals the colour just sent. Otherwise go to IDLE.
- sel_btn in POUR aborts the pour: next state is IDLE.
  - If a handshake happens in the same cycle, that layer still completes; no beat is lost or duplicated.
- conf_btn in POUR is ignored.
- Push and pop never occur in the same cycle, because push_ready is low during POUR.

## Timing
- All state is in registers updated on the rising clk edge.
- Outputs are decoded directly from registers, with no input-to-output combinational path except the pout_ready handshake.
- Reset values:
  - all slots 000, level 0, state IDLE
  - push_err 0, pour_count 0, solved 0
  - so empty=1, full=0, selected=0, confirmed=0, pout_valid=0, push_ready=1
- Push latency: a layer handshaked in cycle n appears on colourN and level in cycle n+1.
- pout_valid rises the cycle after the conf_btn edge. It can sustain one layer per cycle while pout_ready stays high.
- pout_colour is stable while pout_valid=1 and pout_ready=0.
- Reset asserted mid-pour forces IDLE and empties the stack. The destination must treat a pout_valid drop without a handshake as a cancelled beat.

## Configuration
- Macro BOILER_SOLVED_DETECT_EN.
- Defined: solved is registered, =1 when full and all four slots hold equal codes. It updates the cycle after the level/slot change that causes it.
- While solved=1, sel_btn is ignored in IDLE, so a completed boiler cannot be poured.
- Undefined: solved is tied 0 and sel_btn behaves as above with no solved gating.

## Test plan
- Reset, then push 2,2,5,1 with pout_ready held → colour1..4 = 2,2,5,1, level=4, full=1, push_ready=0. A fifth push_valid is not accepted.
- Push 3'b111 into an empty boiler → push_err high for exactly one cycle, level stays 0, colour1=000.
- Stack 4,3,3,3; sel_btn; conf_btn; pout_ready=1 → three beats of code 3 on consecutive cycles, then IDLE. Result: level=1, pour_count=3, colour2..4=000.
- Stack 1,6,6; pour with pout_ready low for 3 cycles → pout_colour holds 6 with no change; on release, two beats are sent and pour_count=2.
- Stack 5,5,5; sel_btn in the same cycle as the first pout handshake → exactly one layer removed (level=2), state IDLE.
- With BOILER_SOLVED_DETECT_EN, push 2,2,2,2 → solved=1 the cycle after the fourth push, and sel_btn leaves selected=0. Without the macro, solved=0 and sel_btn sets selected=1.
